// File: rtl/audio_i2s_ctrl.sv
`timescale 1ns/1ps
// audio_i2s_ctrl: I2S master (64 BCLK/frame) with a one-entry playback buffer, an optional loopback path (AUDIO_I2S_LOOPBACK_EN), and a record deserialiser.
// A pair is sent in the frame after the wrap that loads it, and the record pair is presented at frame end. pb_ready is low while the buffer is full; record output has no backpressure.
module audio_i2s_ctrl #(
  parameter int BCLK_DIV = 16,
  parameter int SAMPLE_W = 24
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] pb_left,
  input  logic [SAMPLE_W-1:0] pb_right,
  input  logic                pb_valid,
  output logic                pb_ready,
  output logic [SAMPLE_W-1:0] rec_left,
  output logic [SAMPLE_W-1:0] rec_right,
  output logic                rec_valid,
  output logic                pb_underrun,
  output logic                BCLK,
  output logic                PBLRCLK,
  output logic                RECLRCLK,
  output logic                PBDATA,
  input  logic                RECDAT
`ifdef AUDIO_I2S_LOOPBACK_EN
  ,
  input  logic                lpbk
`endif
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);
  localparam logic [4:0] SW5      = 5'(SAMPLE_W);

  logic [7:0]          div_cnt;
  logic [5:0]          bit_cnt;
  logic                bclk_q;
  logic                lrclk_q;
  logic                pbdata_q;
  logic                buf_full;
  logic [SAMPLE_W-1:0] buf_l, buf_r;
  logic [SAMPLE_W-1:0] tx_l, tx_r;
  logic [SAMPLE_W-1:0] rec_sh_l, rec_sh_r;
  logic                sync1, sync2;

  logic                tc, rise, fall, wrap, frame_end;
  logic [5:0]          bit_nxt;
  logic                tx_slot, rx_slot, rec_bit;
  logic [SAMPLE_W-1:0] rec_sh_l_nxt, rec_sh_r_nxt;

  always_comb begin
    tc        = en && (div_cnt == DIV_LAST);
    rise      = tc && !bclk_q;
    fall      = tc && bclk_q;
    bit_nxt   = bit_cnt + 6'd1;
    wrap      = fall && (bit_cnt == 6'd63);
    frame_end = rise && (bit_cnt == 6'd63);
    // Transmit slot is judged on the position being entered; receive on the current one.
    tx_slot   = (bit_nxt[4:0] != 5'd0) && (bit_nxt[4:0] <= SW5);
    rx_slot   = rise && (bit_cnt[4:0] != 5'd0) && (bit_cnt[4:0] <= SW5);
`ifdef AUDIO_I2S_LOOPBACK_EN
    rec_bit   = lpbk ? pbdata_q : sync2;
`else
    rec_bit   = sync2;
`endif
    rec_sh_l_nxt = rec_sh_l;
    rec_sh_r_nxt = rec_sh_r;
    if (rx_slot && !bit_cnt[5]) rec_sh_l_nxt = {rec_sh_l[SAMPLE_W-2:0], rec_bit};
    if (rx_slot && bit_cnt[5])  rec_sh_r_nxt = {rec_sh_r[SAMPLE_W-2:0], rec_bit};
  end

  assign pb_ready = ~buf_full;
  assign BCLK     = bclk_q;
  assign PBLRCLK  = lrclk_q;
  assign RECLRCLK = lrclk_q;
  assign PBDATA   = pbdata_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      pbdata_q    <= 1'b0;
      buf_full    <= 1'b0;
      buf_l       <= '0;
      buf_r       <= '0;
      tx_l        <= '0;
      tx_r        <= '0;
      rec_sh_l    <= '0;
      rec_sh_r    <= '0;
      rec_left    <= '0;
      rec_right   <= '0;
      rec_valid   <= 1'b0;
      pb_underrun <= 1'b0;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
    end else begin
      rec_valid   <= 1'b0;
      pb_underrun <= 1'b0;
      sync1       <= RECDAT;
      sync2       <= sync1;

      // At the wrap the buffer is full, so no transfer can coincide with the drain.
      if (wrap && buf_full) begin
        buf_full <= 1'b0;
      end else if (pb_valid && !buf_full) begin
        buf_full <= 1'b1;
        buf_l    <= pb_left;
        buf_r    <= pb_right;
      end

      if (!en) begin
        div_cnt  <= '0;
        bit_cnt  <= '0;
        bclk_q   <= 1'b0;
        lrclk_q  <= 1'b0;
        pbdata_q <= 1'b0;
        tx_l     <= '0;
        tx_r     <= '0;
        rec_sh_l <= '0;
        rec_sh_r <= '0;
      end else begin
        div_cnt <= tc ? 8'd0 : div_cnt + 8'd1;
        if (tc) bclk_q <= ~bclk_q;

        if (fall) begin
          bit_cnt <= bit_nxt;
          lrclk_q <= bit_nxt[5];
          if (wrap) begin
            pbdata_q <= 1'b0;
            if (buf_full) begin
              tx_l <= buf_l;
              tx_r <= buf_r;
            end else begin
              tx_l        <= '0;
              tx_r        <= '0;
              pb_underrun <= 1'b1;
            end
          end else if (tx_slot && !bit_nxt[5]) begin
            {pbdata_q, tx_l} <= {tx_l, 1'b0};
          end else if (tx_slot) begin
            {pbdata_q, tx_r} <= {tx_r, 1'b0};
          end else begin
            pbdata_q <= 1'b0;
          end
        end

        rec_sh_l <= rec_sh_l_nxt;
        rec_sh_r <= rec_sh_r_nxt;
        if (frame_end) begin
          rec_left  <= rec_sh_l_nxt;
          rec_right <= rec_sh_r_nxt;
          rec_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_ctrl.sv
`timescale 1ns/1ps
// Scoreboarded bench for audio_i2s_ctrl: frame and record expectations are queued by the stimulus, popped by a monitor.
module tb_audio_i2s_ctrl;

  localparam int SW = 24;

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    logic          und;
    logic          cmp;
  } pb_exp_t;

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
  } rec_exp_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          en = 1'b0;
  logic [SW-1:0] pb_left = '0, pb_right = '0;
  logic          pb_valid = 1'b0;
  logic          pb_ready;
  logic [SW-1:0] rec_left, rec_right;
  logic          rec_valid, pb_underrun;
  logic          BCLK, PBLRCLK, RECLRCLK, PBDATA;
  logic          RECDAT = 1'b0;
  logic          lpbk = 1'b0;

  audio_i2s_ctrl #(.BCLK_DIV(4), .SAMPLE_W(SW)) dut (
    .aclk(aclk), .aresetn(aresetn), .en(en),
    .pb_left(pb_left), .pb_right(pb_right), .pb_valid(pb_valid), .pb_ready(pb_ready),
    .rec_left(rec_left), .rec_right(rec_right), .rec_valid(rec_valid), .pb_underrun(pb_underrun),
    .BCLK(BCLK), .PBLRCLK(PBLRCLK), .RECLRCLK(RECLRCLK), .PBDATA(PBDATA), .RECDAT(RECDAT)
`ifdef AUDIO_I2S_LOOPBACK_EN
    , .lpbk(lpbk)
`endif
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frames_done = 0;
  pb_exp_t  pb_q[$];
  rec_exp_t rec_q[$];
  logic [SW-1:0] pat_l = 24'h123456, pat_r = 24'hABCDEF;
  logic [5:0]  tb_bit = '0;
  logic [63:0] cap = '0;
  logic        bclk_prev = 1'b0, lr_prev = 1'b0, frame_und = 1'b0;
  logic        cap_en = 1'b0;
  int bclk_r[2];
  int lr_r[2];
  int n_br = 0, n_lr = 0, lr_f = 0;
  logic have_f = 1'b0;

  initial forever #5 aclk = ~aclk;
  initial forever begin @(posedge aclk); cyc++; end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic codec_bit(input logic [5:0] b);
    logic [SW-1:0] w;
    w = b[5] ? pat_r : pat_l;
    if (b[4:0] >= 5'd1 && b[4:0] <= 5'd24) return w[24 - int'(b[4:0])];
    return 1'b0;
  endfunction

  task automatic check_frame();
    logic [SW-1:0] gl, gr;
    logic extra;
    pb_exp_t e;
    extra = 1'b0;
    for (int i = 0; i < SW; i++) begin
      gl[SW-1-i] = cap[1+i];
      gr[SW-1-i] = cap[33+i];
    end
    for (int i = 0; i < 64; i++)
      if (!(i >= 1 && i <= SW) && !(i >= 33 && i <= 32 + SW)) extra |= cap[i];
    chk("pb_frame_expected", 64'(pb_q.size() != 0), 64'd1);
    if (pb_q.size() != 0) begin
      e = pb_q.pop_front();
      chk("pb_underrun_flag", 64'(frame_und), 64'(e.und));
      if (e.cmp) begin
        chk("pbdata_left", 64'(gl), 64'(e.l));
        chk("pbdata_right", 64'(gr), 64'(e.r));
        chk("pbdata_pad_zero", 64'(extra), 64'd0);
      end
    end
  endtask

  // Monitor and codec model: tracks slot position from BCLK, drives RECDAT after each BCLK fall.
  initial begin
    logic rose, fell, at63;
    rec_exp_t re;
    forever begin
      @(negedge aclk);
      rose = 1'b0; fell = 1'b0; at63 = 1'b0;
      if (!aresetn || !en) begin
        tb_bit = '0; bclk_prev = 1'b0; lr_prev = 1'b0; frame_und = 1'b0; cap = '0; RECDAT = 1'b0;
        if (aresetn && pb_underrun) chk("und_while_off", 64'(pb_underrun), 64'd0);
      end else begin
        rose = BCLK && !bclk_prev;
        fell = !BCLK && bclk_prev;
        if (rose) begin
          cap[tb_bit] = PBDATA;
          if (cap_en && n_br < 2) begin bclk_r[n_br] = cyc; n_br++; end
          if (tb_bit == 6'd63) begin
            at63 = 1'b1;
            frames_done++;
            check_frame();
          end
        end
        if (fell) begin
          tb_bit = tb_bit + 6'd1;
          if (tb_bit == 6'd0) begin frame_und = pb_underrun; cap = '0; end
          RECDAT = codec_bit(tb_bit);
        end
        if (pb_underrun && !(fell && tb_bit == 6'd0)) chk("und_unexpected", 64'(pb_underrun), 64'd0);
        if (PBLRCLK != lr_prev) begin
          chk("reclrclk_eq_pblrclk", 64'(RECLRCLK), 64'(PBLRCLK));
          if (cap_en) begin
            if (PBLRCLK) begin
              if (n_lr < 2) lr_r[n_lr] = cyc;
              n_lr++;
            end else if (n_lr == 1 && !have_f) begin
              lr_f = cyc; have_f = 1'b1;
            end
          end
        end
        lr_prev = PBLRCLK;
        bclk_prev = BCLK;
      end
      if (rec_valid) begin
        chk("rec_valid_at_bit63", 64'(at63), 64'd1);
        chk("rec_expected", 64'(rec_q.size() != 0), 64'd1);
        if (rec_q.size() != 0) begin
          re = rec_q.pop_front();
          chk("rec_left", 64'(rec_left), 64'(re.l));
          chk("rec_right", 64'(rec_right), 64'(re.r));
        end
      end
    end
  end

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done < target && n < 3000) begin @(posedge aclk); n++; end
    chk("frames_reached", 64'(frames_done), 64'(target));
    #1;
  endtask

  task automatic wait_bit(input logic [5:0] b);
    int n = 0;
    while (tb_bit != b && n < 2000) begin @(posedge aclk); n++; end
    chk("bit_reached", 64'(tb_bit), 64'(b));
    #1;
  endtask

  task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r);
    int n = 0;
    logic done = 1'b0;
    pb_left = l; pb_right = r; pb_valid = 1'b1;
    while (!done && n < 2000) begin
      @(negedge aclk);
      n++;
      if (pb_ready) begin @(posedge aclk); #1; done = 1'b1; end
    end
    pb_valid = 1'b0;
    chk("pb_accepted", 64'(done), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_bclk"}, 64'(BCLK), 64'd0);
    chk({tag, "_pblrclk"}, 64'(PBLRCLK), 64'd0);
    chk({tag, "_reclrclk"}, 64'(RECLRCLK), 64'd0);
    chk({tag, "_pbdata"}, 64'(PBDATA), 64'd0);
  endtask

  initial begin
    int r0, base;
    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check_idle_outputs("rst");
    chk("rst_rec_valid", 64'(rec_valid), 64'd0);
    chk("rst_underrun", 64'(pb_underrun), 64'd0);
    chk("rst_rec_lr", 64'({rec_left, rec_right}), 64'd0);
    chk("rst_pb_ready", 64'(pb_ready), 64'd1);

    // Normal run: zero frame, loaded pair, then underrun frame
    pb_q.push_back('{l: '0, r: '0, und: 1'b0, cmp: 1'b1});
    pb_q.push_back('{l: 24'h800001, r: 24'h7FFFFF, und: 1'b0, cmp: 1'b1});
    pb_q.push_back('{l: '0, r: '0, und: 1'b1, cmp: 1'b1});
    for (int i = 0; i < 3; i++) rec_q.push_back('{l: 24'h123456, r: 24'hABCDEF});
    cap_en = 1'b1;
    aresetn = 1'b1; en = 1'b1; r0 = cyc;
    send(24'h800001, 24'h7FFFFF);
    chk("pb_ready_full", 64'(pb_ready), 64'd0);
    wait_frames(2);
    chk("pb_ready_after_load", 64'(pb_ready), 64'd1);
    wait_frames(3);
    chk("pb_ready_after_underrun", 64'(pb_ready), 64'd1);
    cap_en = 1'b0;
    chk("bclk_first_rise", 64'(bclk_r[0] - r0), 64'd4);
    chk("bclk_period", 64'(bclk_r[1] - bclk_r[0]), 64'd8);
    chk("lrclk_low_first", 64'(lr_r[0] - r0), 64'd256);
    chk("lrclk_period", 64'(lr_r[1] - lr_r[0]), 64'd512);
    chk("lrclk_high_time", 64'(lr_f - lr_r[0]), 64'd256);

    // Reset at bit 40: immediate zero outputs, aborted frame expects nothing
    wait_bit(6'd40);
    @(posedge aclk); #1;
    aresetn = 1'b0;
    #1;
    check_idle_outputs("midrst");
    chk("midrst_rec_lr", 64'({rec_left, rec_right}), 64'd0);
    chk("midrst_rec_valid", 64'(rec_valid), 64'd0);
    chk("midrst_pb_ready", 64'(pb_ready), 64'd1);
    pat_l = 24'hFEDCBA; pat_r = 24'h0A0B0C;
    repeat (3) @(posedge aclk);
    #1;
    base = frames_done;
    pb_q.push_back('{l: '0, r: '0, und: 1'b0, cmp: 1'b1});
    rec_q.push_back('{l: 24'hFEDCBA, r: 24'h0A0B0C});
    aresetn = 1'b1;
    send(24'h000F0F, 24'hF0F000);
    wait_frames(base + 1);
    send(24'h3C3C3C, 24'h0C3C30);
    chk("pb_ready_p3_held", 64'(pb_ready), 64'd0);

    // Enable dropped mid right slot: clocks and data clear, buffer retained
    wait_bit(6'd36);
    chk("pre_off_pbdata", 64'(PBDATA), 64'd1);
    chk("pre_off_lrclk", 64'(PBLRCLK), 64'd1);
    en = 1'b0;
    @(posedge aclk); #1;
    check_idle_outputs("en_off");
    pat_l = 24'h5A0F3C; pat_r = 24'h00FF11;
    repeat (600) @(posedge aclk);
    #1;
    chk("en_off_buffer_kept", 64'(pb_ready), 64'd0);
    base = frames_done;
    pb_q.push_back('{l: '0, r: '0, und: 1'b0, cmp: 1'b0});
    pb_q.push_back('{l: 24'h3C3C3C, r: 24'h0C3C30, und: 1'b0, cmp: 1'b1});
    rec_q.push_back('{l: 24'h5A0F3C, r: 24'h00FF11});
    rec_q.push_back('{l: 24'h5A0F3C, r: 24'h00FF11});
    en = 1'b1;
    wait_frames(base + 1);
    send(24'h00A5A5, 24'h5A5A00);
    wait_frames(base + 2);

    // Loopback frame (codec data when the feature is not built)
    lpbk = 1'b1;
    pb_q.push_back('{l: 24'h00A5A5, r: 24'h5A5A00, und: 1'b0, cmp: 1'b1});
`ifdef AUDIO_I2S_LOOPBACK_EN
    rec_q.push_back('{l: 24'h00A5A5, r: 24'h5A5A00});
`else
    rec_q.push_back('{l: 24'h5A0F3C, r: 24'h00FF11});
`endif
    wait_frames(base + 3);
    lpbk = 1'b0;
    chk("pb_queue_drained", 64'(pb_q.size()), 64'd0);
    chk("rec_queue_drained", 64'(rec_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_i2s_ctrl.md
AUDIO_I2S_CTRL -- requirements
Module: audio_i2s_ctrl

Interface
REQ-001 Parameter BCLK_DIV, default 16: aclk cycles per BCLK half-period; legal 4..255.
REQ-002 Parameter SAMPLE_W, default 24: audio sample width; legal 16..31.
REQ-003 aclk  input  1  sole clock; all logic rising-edge.
REQ-004 aresetn  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  run enable; low stops the serial clocks.
REQ-006 pb_left, pb_right  input  SAMPLE_W each  playback sample pair, two's complement.
REQ-007 pb_valid / pb_ready  input / output  1 / 1  playback handshake.
REQ-008 rec_left, rec_right  output  SAMPLE_W each  captured sample pair.
REQ-009 rec_valid  output  1  one-aclk pulse when a new record pair is presented.
REQ-010 pb_underrun  output  1  one-aclk pulse when a frame starts with no playback pair buffered.
REQ-011 BCLK, PBLRCLK, RECLRCLK, PBDATA  output  1 each  codec serial outputs, all registered.
REQ-012 RECDAT  input  1  codec record serial data, asynchronous to aclk.

Function
REQ-013 Divider div_cnt counts 0..BCLK_DIV-1 while en=1; on terminal count BCLK toggles and div_cnt returns to 0.
REQ-014 The toggle 0->1 is a rise event and 1->0 is a fall event.
REQ-015 bit_cnt (6 bits) advances on each fall event and wraps 63->0, giving 64 BCLK per frame.
REQ-016 PBLRCLK = RECLRCLK = bit_cnt[5], registered: low = left slot (bits 0..31), high = right slot (32..63).
REQ-017 Slot position p = bit_cnt[4:0].
REQ-018 PBDATA updates on fall events: p=1..SAMPLE_W drives sample bit SAMPLE_W-p, MSB first; all other p drive 0 (standard I2S one-bit delay).
REQ-019 Playback holding buffer is one entry; pb_ready = not buffer-full; transfer when pb_valid and pb_ready are both high on an aclk edge.
REQ-020 On the fall event where bit_cnt wraps to 0, a full buffer moves into the transmit shift registers and is marked empty.
REQ-021 If the buffer is empty at that event, the frame transmits all zeros and pb_underrun pulses.
REQ-022 A transfer on that same aclk edge fills the buffer for the next frame; the underrun still applies to the current frame.
REQ-023 RECDAT passes through a 2-flop synchronizer and is sampled on rise events at p=1..SAMPLE_W into the slot's shift register, MSB first.
REQ-024 At the rise event with bit_cnt=63, rec_left/rec_right update and rec_valid pulses for 1 cycle; data holds until the next frame; no backpressure.
REQ-025 en low: div_cnt, bit_cnt, BCLK, LR clocks and PBDATA return to 0 on the next aclk; buffer contents retained; no rec_valid or pb_underrun.
REQ-026 en rising: first frame starts at bit_cnt=0 and obeys REQ-020/021 at its first wrap.

Reset
REQ-027 aresetn low, asynchronously: BCLK, PBLRCLK, RECLRCLK, PBDATA, rec_valid, pb_underrun = 0; rec_left/right = 0; counters = 0; buffer empty (pb_ready = 1).
REQ-028 Reset mid-frame aborts the frame with no partial rec_valid; operation restarts at bit_cnt=0 after release.

Configuration
REQ-029 Macro AUDIO_I2S_LOOPBACK_EN defined: extra input lpbk (1 bit); lpbk=1 feeds the registered PBDATA into the record shifter in place of synchronized RECDAT.
REQ-030 Macro AUDIO_I2S_LOOPBACK_EN undefined: no lpbk port; the record path always uses RECDAT.

Verification
REQ-031 BCLK_DIV=4, en=1 -> BCLK period 8 aclk; PBLRCLK period 512 aclk, 50% duty, low first after reset.
REQ-032 Load pb_left=0x800001, pb_right=0x7FFFFF before the first wrap -> PBDATA carries left bits 1,0x22,1 then right 0,1x23, each preceded by one 0 bit, then zeros to slot end.
REQ-033 Hold pb_valid low through a wrap -> one pb_underrun pulse, zero frame; pb_ready stays 1.
REQ-034 Codec model drives RECDAT left=0x123456, right=0xABCDEF -> rec_valid pulse at frame end with exactly those values.
REQ-035 Assert aresetn low at bit_cnt=40 -> all outputs 0 in the same cycle, no rec_valid; clean frame after release.
REQ-036 With AUDIO_I2S_LOOPBACK_EN, lpbk=1, play 0x00A5A5/0x5A5A00 -> rec_left/right equal these values one frame later.
